// File: rtl/cifrador_pkg.sv
// Shared types and helpers for the parametrised Feistel cipher core.
// Helpers work on a fixed-width word; the caller passes the live half-width.
package cifrador_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  localparam int unsigned MAXH  = 32;
  localparam int unsigned MAXHW = 5;

  typedef logic [MAXH-1:0] word_t;

  // Rotate the low h bits of x left by n; bits at and above h read as zero.
  function automatic word_t rotl_h(
    input word_t       x,
    input int unsigned n,
    input int unsigned h
  );
    word_t            r;
    logic [MAXHW-1:0] p;
    r = '0;
    for (int unsigned b = 0; b < MAXH; b++) begin
      if (b < h) begin
        p    = MAXHW'((b + n) % h);
        r[p] = x[b];
      end
    end
    return r;
  endfunction

  function automatic word_t round_key(
    input word_t       key,
    input int unsigned i,
    input int unsigned h
  );
    word_t iv;
    iv = word_t'(i);
    for (int unsigned b = 0; b < MAXH; b++) begin
      if (b >= h) iv[b] = 1'b0;
    end
    return rotl_h(key, i % h, h) ^ iv;
  endfunction

endpackage

// File: rtl/cifrador_round.sv
// One combinational Feistel round; direction selects which half feeds F.
// F(x,K) = rotl(x ^ K, 1) on H bits.
module cifrador_round
  import cifrador_pkg::*;
#(
  parameter int H = 4
) (
  input  logic [H-1:0] l_i,
  input  logic [H-1:0] r_i,
  input  logic [H-1:0] k_i,
  input  logic         mode_i,
  output logic [H-1:0] l_o,
  output logic [H-1:0] r_o
);

  logic [H-1:0] x;
  logic [H-1:0] f;

  assign x = (mode_i == MODE_DEC) ? l_i : r_i;
  assign f = H'(rotl_h(word_t'(x ^ k_i), 1, H));

  always_comb begin
    l_o = r_i;
    r_o = l_i ^ f;
    if (mode_i == MODE_DEC) begin
      l_o = r_i ^ f;
      r_o = l_i;
    end
  end

endmodule

// File: rtl/cifrador_nbits.sv
// Iterative Feistel cipher core: one round per clock, valid/ready on both
// sides, runtime key register writable only while idle.
module cifrador_nbits
  import cifrador_pkg::*;
#(
  parameter  int W      = 8,
  parameter  int ROUNDS = 4,
  localparam int H      = W / 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_we,
  input  logic [H-1:0] key_in,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         busy
);

  localparam int CW = $clog2(ROUNDS + 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q;
  logic [H-1:0]   key_q;
  logic [H-1:0]   l_q, r_q;
  logic           mode_q;
  logic           ov_q;
  logic [W-1:0]   od_q;

  logic [CW-1:0]  rnd;
  logic [H-1:0]   rk;
  logic [H-1:0]   l_n, r_n;
  logic           last;

  assign last = (cnt_q == CW'(ROUNDS - 1));
  assign rnd  = (mode_q == MODE_DEC) ? CW'(ROUNDS - 1) - cnt_q : cnt_q;
  assign rk   = H'(round_key(word_t'(key_q), int'(rnd), H));

  cifrador_round #(.H(H)) u_round (
    .l_i    (l_q),
    .r_i    (r_q),
    .k_i    (rk),
    .mode_i (mode_q),
    .l_o    (l_n),
    .r_o    (r_n)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid)  state_d = RUN;
      RUN:  if (last)      state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      IDLE:     in_ready = 1'b1;
      RUN,
      DONE:     busy     = 1'b1;
      default:  busy     = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      key_q  <= '0;
      l_q    <= '0;
      r_q    <= '0;
      mode_q <= MODE_ENC;
      ov_q   <= 1'b0;
      od_q   <= '0;
    end else begin
      // A key written alongside an accept is already in place for round 0.
      if (state_q == IDLE && key_we) key_q <= key_in;
      unique case (state_q)
        IDLE: if (in_valid) begin
          l_q    <= in_data[W-1:H];
          r_q    <= in_data[H-1:0];
          mode_q <= mode;
          cnt_q  <= '0;
        end
        RUN: begin
          l_q   <= l_n;
          r_q   <= r_n;
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            ov_q <= 1'b1;
            od_q <= {l_n, r_n};
          end
        end
        DONE: if (out_ready) ov_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign out_valid = ov_q;
  assign out_data  = od_q;

endmodule

// File: tb/tb_cifrador_nbits.sv
// Bench for cifrador_nbits: 8-bit vector table plus abort sequence,
// and a 16-bit random encrypt/decrypt round-trip with output stalls.
module tb_cifrador_nbits;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic       k8_we, iv8, ir8, md8, ov8, or8, bz8;
  logic [3:0] k8_in;
  logic [7:0] id8, od8;

  logic        k16_we, iv16, ir16, md16, ov16, or16, bz16;
  logic [7:0]  k16_in;
  logic [15:0] id16, od16;

  cifrador_nbits #(.W(8), .ROUNDS(4)) u8 (
    .clk(clk), .rst(rst), .key_we(k8_we), .key_in(k8_in),
    .in_valid(iv8), .in_ready(ir8), .in_data(id8), .mode(md8),
    .out_valid(ov8), .out_ready(or8), .out_data(od8), .busy(bz8)
  );

  cifrador_nbits #(.W(16), .ROUNDS(8)) u16 (
    .clk(clk), .rst(rst), .key_we(k16_we), .key_in(k16_in),
    .in_valid(iv16), .in_ready(ir16), .in_data(id16), .mode(md16),
    .out_valid(ov16), .out_ready(or16), .out_data(od16), .busy(bz16)
  );

  logic [7:0]  q8[$];
  logic [15:0] q16[$];
  int          n16_out = 0;

  typedef struct {
    logic       we;
    logic [3:0] key;
    logic [7:0] din;
    logic       mode;
    logic [7:0] exp;
    int         hold;
    logic       kick;
  } vec8_t;

  vec8_t tv[6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int unsigned rotl(input int unsigned x,
      input int unsigned n, input int unsigned h, input int unsigned mask);
    return ((x << n) | (x >> (h - n))) & mask;
  endfunction

  function automatic logic [31:0] model(input int unsigned h,
      input int unsigned rounds, input int unsigned key,
      input int unsigned din, input bit dec);
    int unsigned mask, l, r, k, t, i;
    mask = (1 << h) - 1;
    l = (din >> h) & mask;
    r = din & mask;
    for (int unsigned j = 0; j < rounds; j++) begin
      i = dec ? rounds - 1 - j : j;
      k = rotl(key & mask, i % h, h, mask) ^ (i & mask);
      if (!dec) begin
        t = l ^ rotl(r ^ k, 1, h, mask); l = r; r = t;
      end else begin
        t = r ^ rotl(l ^ k, 1, h, mask); r = l; l = t;
      end
    end
    return (l << h) | r;
  endfunction

  task automatic send8(input logic we, input logic [3:0] k,
                       input logic [7:0] d, input logic m, input logic kick);
    int lat;
    @(negedge clk);
    chk("ir8_idle", ir8, 1);
    k8_we = we; k8_in = k; id8 = d; md8 = m; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0; k8_we = kick; k8_in = 4'hF; md8 = ~m;
    lat = 0;
    while (!ov8 && lat < 20) begin
      if (lat == 1) chk("busy8_run", bz8, 1);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency8", lat, 4);
  endtask

  task automatic recv8(input int hold);
    logic [7:0] e;
    if (q8.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL q8_underflow: got %0h want none", od8);
      return;
    end
    e = q8.pop_front();
    chk("od8", od8, e);
    chk("ov8", ov8, 1);
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      chk("od8_hold", od8, e);
      chk("ir8_hold", ir8, 0);
      chk("busy8_done", bz8, 1);
    end
    @(negedge clk); or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0; k8_we = 1'b0;
    chk("ov8_clr", ov8, 0);
    chk("od8_keep", od8, e);
  endtask

  task automatic send16(input logic [7:0] k, input logic [15:0] d,
                        input logic m);
    int lat;
    @(negedge clk);
    chk("ir16_idle", ir16, 1);
    k16_we = 1'b1; k16_in = k; id16 = d; md16 = m; iv16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0; k16_we = 1'b0; md16 = ~m;
    lat = 0;
    while (!ov16 && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency16", lat, 8);
  endtask

  task automatic recv16(input int hold);
    logic [15:0] e;
    if (q16.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL q16_underflow: got %0h want none", od16);
      return;
    end
    e = q16.pop_front();
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
    end
    chk("od16", od16, e);
    @(negedge clk); or16 = 1'b1;
    @(posedge clk); #1;
    or16 = 1'b0;
    n16_out++;
    chk("ov16_clr", ov16, 0);
  endtask

  initial begin
    logic [7:0]  key;
    logic [15:0] d, c;

    tv[0] = '{1'b1, 4'h3, 8'hA5, 1'b0, 8'h58, 0, 1'b0};
    tv[1] = '{1'b1, 4'h3, 8'h58, 1'b1, 8'hA5, 0, 1'b0};
    tv[2] = '{1'b1, 4'h0, 8'hA5, 1'b0, 8'hA4, 0, 1'b0};
    tv[3] = '{1'b1, 4'h3, 8'hA5, 1'b0, 8'h58, 0, 1'b0};
    tv[4] = '{1'b0, 4'h0, 8'hA5, 1'b0, 8'h58, 5, 1'b1};
    tv[5] = '{1'b0, 4'h0, 8'hA5, 1'b0, 8'h58, 0, 1'b0};

    rst = 1'b1;
    k8_we = 0; k8_in = 0; iv8 = 0; id8 = 0; md8 = 0; or8 = 0;
    k16_we = 0; k16_in = 0; iv16 = 0; id16 = 0; md16 = 0; or16 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ov8", ov8, 0);
    chk("rst_od8", od8, 0);
    chk("rst_ir8", ir8, 1);
    chk("rst_busy8", bz8, 0);
    chk("rst_ov16", ov16, 0);
    chk("rst_od16", od16, 0);
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      q8.push_back(tv[v].exp);
      send8(tv[v].we, tv[v].key, tv[v].din, tv[v].mode, tv[v].kick);
      recv8(tv[v].hold);
    end

    // Abort after two rounds; the block must vanish and the key clear.
    @(negedge clk);
    id8 = 8'hA5; md8 = 1'b0; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_ov8", ov8, 0);
    chk("abort_ir8", ir8, 1);
    chk("abort_busy8", bz8, 0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("abort_quiet", ov8, 0);
    end
    q8.push_back(8'hA4);
    send8(1'b0, 4'h0, 8'hA5, 1'b0, 1'b0);
    recv8(0);

    for (int n = 0; n < 200; n++) begin
      key = 8'($urandom);
      d   = 16'($urandom);
      c   = 16'(model(8, 8, key, d, 1'b0));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      q16.push_back(c);
      send16(key, d, 1'b0);
      recv16($urandom_range(0, 3));
      q16.push_back(d);
      send16(key, c, 1'b1);
      recv16($urandom_range(0, 3));
    end
    chk("n16_out", n16_out, 400);
    chk("q16_drained", q16.size(), 0);
    chk("q8_drained", q8.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cifrador_nbits.md
Name: cifrador_nbits

Overview:
- Parametrised, iterative Feistel block cipher; successor to the fixed 8-bit cifrador.
- Block width, round count and encrypt/decrypt mode are configurable; one round is computed per clock.
- Blocks enter and leave through valid/ready handshakes; the round key is loadable at runtime.
- Sits between the tt_um top-level pin mapping (ui_in/uo_out) and the user I/O; it is the datapath core.

Parameters:
- W, 8: block width in bits; even, at least 4. H = W/2 is the half-block and key width.
- ROUNDS, 4: Feistel rounds per block; at least 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- key_we  in  1  key write strobe.
- key_in  in  H  key value.
- in_valid  in  1  input block valid.
- in_ready  out  1  block accepted when in_valid && in_ready.
- in_data  in  W  input block; {L,R} = {in_data[W-1:H], in_data[H-1:0]}.
- mode  in  1  0 = encrypt, 1 = decrypt; sampled at accept.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream ready.
- out_data  out  W  result {L,R}.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset values: out_valid=0, out_data=0, key register=0, state=IDLE, round counter=0.
  - in_ready=1 and busy=0 follow from state IDLE.
- Reset asserted mid-operation aborts the block. No output is produced for it.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On accept: load L/R, latch mode, set cnt=0, go to RUN.
- Key load:
  - key_we is honoured only in IDLE; it is ignored in RUN and DONE.
  - A key_we in the same cycle as an accept is applied, and that block uses the new key.
- Round key: K_i = rotl_H(key, i mod H) XOR i[H-1:0].
- Round function: F(x,K) = rotl_H(x XOR K, 1).
- RUN, one round per edge:
  - Encrypt round i = cnt: L' = R, R' = L ^ F(R, K_i).
  - Decrypt round i = ROUNDS-1-cnt: R' = L, L' = R ^ F(L, K_i).
  - Decrypt exactly inverts encrypt.
- Round completion:
  - cnt increments after each round.
  - On the edge completing the last round: go to DONE, out_valid=1, out_data={L',R'}.
- Latency: out_valid rises exactly ROUNDS edges after the accept edge.
- DONE:
  - out_data and out_valid are held stable while out_ready=0.
  - On out_valid && out_ready: out_valid=0, go to IDLE. out_data keeps its last value.
- Throughput: one block per ROUNDS+2 cycles, given out_ready=1 and in_valid held high.
- Ignored inputs: in_valid and mode outside IDLE.
- Round counter width: $clog2(ROUNDS+1).
- All arithmetic is modulo 2^H. There are no adders, only XOR and rotate.

Decomposition:
- Package cifrador_pkg:
  - state enum {IDLE, RUN, DONE};
  - MODE_ENC/MODE_DEC constants;
  - functions rotl_h and round_key.
- Sub-module cifrador_round:
  - combinational single round;
  - inputs L, R, K, mode; outputs L', R';
  - parametrised by H.
- Top module: FSM, counter, key register, L/R registers and handshake logic.

Test Plan:
1. W=8, ROUNDS=4. Load key 0x3, encrypt 0xA5 -> out_data 0x58; out_valid rises 4 edges after accept; busy high during RUN and DONE.
2. Same config. Decrypt 0x58 with key 0x3 -> 0xA5. Encrypt 0xA5 with key 0x0 -> 0xA4.
3. Backpressure: after test 1, hold out_ready=0 for 5 cycles -> out_data stays 0x58, in_ready=0. key_we=1 with 0xF during RUN is ignored; a re-encrypt of 0xA5 still gives 0x58.
4. Reset after 2 rounds of an encrypt -> next cycle out_valid=0, in_ready=1, busy=0, no result emitted. Next encrypt of 0xA5 gives 0xA4, since the key has been cleared to 0.
5. Same cycle key_we=1 (key 0x3) and accept of 0xA5 in IDLE -> result 0x58.
6. W=16, ROUNDS=8: 200 random key/data pairs, encrypt then decrypt -> identity. Random out_ready stalls cause no lost or duplicated outputs.
